// File: rtl/tile_hit_scorer.sv
// tile_hit_scorer: judges synchronized KEY presses against the latched hit-zone pattern,
// keeps BCD score and lives, and runs the IDLE/PLAY/OVER game state machine.
module tile_hit_scorer #(
  parameter int LANES      = 4,
  parameter int LIVES_INIT = 3,
  parameter int SCORE_MAX  = 999
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [LANES-1:0] KEY,
  input  logic             t,
  input  logic [LANES-1:0] tile_lanes,
  output logic [11:0]      score_bcd,
  output logic [1:0]       lives,
  output logic [1:0]       game_state,
  output logic             hit_pulse,
  output logic             miss_pulse
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;
  localparam logic [11:0] MAX_BCD = {4'(SCORE_MAX / 100), 4'((SCORE_MAX / 10) % 10), 4'(SCORE_MAX % 10)};
  state_t           r_state;
  logic [LANES-1:0] r_sync1, r_sync2, r_hist, r_target, r_hitmask;
  logic [11:0]      r_score;
  logic [1:0]       r_lives;
  logic             r_hit, r_miss;
  logic [LANES-1:0] w_press, w_open, w_correct, w_wrong;
  logic             w_miss;
  logic [3:0]       w_cnt;
  logic [4:0]       w_d0, w_d1, w_d2;
  logic             w_c0, w_c1, w_c2;
  logic [11:0]      w_sum, w_next_score;
  assign w_press   = r_sync2 & ~r_hist;
  assign w_open    = r_target & ~r_hitmask;
  assign w_correct = w_press & w_open;
  assign w_wrong   = w_press & ~w_open;
  // a window close and a wrong press in the same cycle still cost only one life
  assign w_miss    = (|w_wrong) | (t & |(r_target & ~(r_hitmask | w_correct)));
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < LANES; i++) w_cnt = w_cnt + 4'(w_press[i]);
  end
  assign w_d0 = {1'b0, r_score[3:0]} + 5'(w_cnt);
  assign w_c0 = w_d0 > 5'd9;
  assign w_d1 = {1'b0, r_score[7:4]} + 5'(w_c0);
  assign w_c1 = w_d1 > 5'd9;
  assign w_d2 = {1'b0, r_score[11:8]} + 5'(w_c1);
  assign w_c2 = w_d2 > 5'd9;
  assign w_sum = {w_c2 ? 4'(w_d2 - 5'd10) : w_d2[3:0],
                  w_c1 ? 4'(w_d1 - 5'd10) : w_d1[3:0],
                  w_c0 ? 4'(w_d0 - 5'd10) : w_d0[3:0]};
  assign w_next_score = (w_c2 || w_sum > MAX_BCD) ? MAX_BCD : w_sum;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_score   <= '0;
      r_lives   <= 2'(LIVES_INIT);
      r_target  <= '0;
      r_hitmask <= '0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_hist    <= '0;
    end else begin
      r_sync1 <= ~KEY;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      case (r_state)
        S_IDLE: if (|w_press) begin
          r_state   <= S_PLAY;
          r_score   <= '0;
          r_lives   <= 2'(LIVES_INIT);
          r_target  <= '0;
          r_hitmask <= '0;
        end
        S_PLAY: begin
          if (t) r_target <= tile_lanes;
          r_hitmask <= t ? '0 : (r_hitmask | w_correct);
          if (!(|w_wrong) && (|w_press)) begin
            r_score <= w_next_score;
            r_hit   <= 1'b1;
          end
          if (w_miss) begin
            r_lives <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
            r_miss  <= 1'b1;
          end
          if (r_lives == 2'd0) r_state <= S_OVER;
        end
        S_OVER: if (|w_press) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign score_bcd  = r_score;
  assign lives      = r_lives;
  assign game_state = r_state;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;
endmodule

// File: tb/tb_tile_hit_scorer.sv
// tb_tile_hit_scorer: directed scenarios plus a randomized run against an integer-level game model.
module tb_tile_hit_scorer;
  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  KEY, tile_lanes;
  logic        t;
  logic [11:0] score_bcd;
  logic [1:0]  lives, game_state;
  logic        hit_pulse, miss_pulse;
  int checks = 0, errors = 0;
  int m_state, m_score, m_lives, m_hits, m_misses, d_hits, d_misses;
  logic [3:0] m_tgt, m_hm, ph0, ph1, ph2;
  tile_hit_scorer #(.LANES(4), .LIVES_INIT(3), .SCORE_MAX(999)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY), .t(t), .tile_lanes(tile_lanes),
    .score_bcd(score_bcd), .lives(lives), .game_state(game_state),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));
  always #5 CLOCK_50 = ~CLOCK_50;
  function automatic logic [11:0] m_bcd();
    return {4'(m_score / 100), 4'((m_score / 10) % 10), 4'(m_score % 10)};
  endfunction
  task automatic model_reset();
    m_state = 0; m_score = 0; m_lives = 3; m_tgt = 0; m_hm = 0;
    ph0 = 0; ph1 = 0; ph2 = 0;
  endtask
  // pressed level seen 2 and 3 edges ago gives one press per physical press
  task automatic tick();
    logic [3:0] p, op, wr, co;
    bit miss, hit;
    int nxt;
    p = ph1 & ~ph2; miss = 0; hit = 0;
    if (reset) model_reset();
    else begin
      case (m_state)
        0: if (p != 0) begin m_state = 1; m_score = 0; m_lives = 3; m_tgt = 0; m_hm = 0; end
        1: begin
          op = m_tgt & ~m_hm; wr = p & ~op; co = p & op;
          if (t && (m_tgt & ~(m_hm | co)) != 0) miss = 1;
          if (wr != 0) miss = 1;
          else if (p != 0) begin
            hit = 1;
            m_score = (m_score + $countones(p) > 999) ? 999 : m_score + $countones(p);
          end
          nxt = (m_lives == 0) ? 2 : 1;
          if (miss && m_lives > 0) m_lives--;
          m_hm = t ? 4'b0 : (m_hm | co);
          if (t) m_tgt = tile_lanes;
          m_state = nxt;
        end
        default: if (p != 0) m_state = 0;
      endcase
      ph2 = ph1; ph1 = ph0; ph0 = ~KEY;
    end
    if (hit) m_hits++;
    if (miss) m_misses++;
    @(posedge CLOCK_50); #1;
    if (hit_pulse) d_hits++;
    if (miss_pulse) d_misses++;
  endtask
  task automatic step_t(input logic [3:0] lanes);
    t = 1; tile_lanes = lanes; tick(); t = 0; tile_lanes = 4'($urandom);
  endtask
  task automatic press(input logic [3:0] mask);
    KEY = ~mask; tick(); KEY = 4'hF; repeat (4) tick();
  endtask
  task automatic test_reset();
    reset = 1; KEY = 4'hF; t = 0; tile_lanes = 0;
    repeat (2) tick();
    reset = 0;
    checks += 4;
    if (score_bcd !== 12'h000) begin errors++; $display("FAIL reset_score got %h exp 000", score_bcd); end
    if (lives !== 2'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", lives); end
    if (game_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", game_state); end
    if ({hit_pulse, miss_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {hit_pulse, miss_pulse}); end
    press(4'b0001);
    repeat (3) begin step_t(4'b1111); press(4'b1111); end
    checks += 2;
    if (game_state !== 2'b01) begin errors++; $display("FAIL start_state got %b exp 01", game_state); end
    if (score_bcd !== 12'h012) begin errors++; $display("FAIL score12 got %h exp 012", score_bcd); end
    reset = 1; #1;
    checks += 3;
    if (score_bcd !== 12'h000) begin errors++; $display("FAIL async_reset_score got %h exp 000", score_bcd); end
    if (lives !== 2'd3) begin errors++; $display("FAIL async_reset_lives got %0d exp 3", lives); end
    if (game_state !== 2'b00) begin errors++; $display("FAIL async_reset_state got %b exp 00", game_state); end
    tick(); reset = 0;
    step_t(4'b0001); tick();
    checks += 2;
    if (game_state !== 2'b00) begin errors++; $display("FAIL idle_t_state got %b exp 00", game_state); end
    if (score_bcd !== 12'h000 || lives !== 2'd3) begin errors++; $display("FAIL idle_t_regs got %h/%0d exp 000/3", score_bcd, lives); end
  endtask
  task automatic test_single_hit();
    int h0;
    press(4'b0001);
    step_t(4'b0100);
    h0 = d_hits;
    KEY = 4'b1011; repeat (100) tick(); KEY = 4'hF; repeat (4) tick();
    checks += 3;
    if (d_hits - h0 !== 1) begin errors++; $display("FAIL single_hit_pulses got %0d exp 1", d_hits - h0); end
    if (score_bcd !== 12'h001) begin errors++; $display("FAIL single_hit_score got %h exp 001", score_bcd); end
    if (lives !== 2'd3) begin errors++; $display("FAIL single_hit_lives got %0d exp 3", lives); end
  endtask
  task automatic test_carry();
    int h0;
    repeat (24) begin step_t(4'b1111); press(4'b1111); end
    step_t(4'b0001); press(4'b0001);
    checks += 1;
    if (score_bcd !== 12'h098) begin errors++; $display("FAIL pre_carry_score got %h exp 098", score_bcd); end
    step_t(4'b0011);
    h0 = d_hits;
    press(4'b0011);
    checks += 3;
    if (score_bcd !== 12'h100) begin errors++; $display("FAIL carry_score got %h exp 100", score_bcd); end
    if (d_hits - h0 !== 1) begin errors++; $display("FAIL carry_pulses got %0d exp 1", d_hits - h0); end
    if (lives !== 2'd3) begin errors++; $display("FAIL carry_lives got %0d exp 3", lives); end
  endtask
  task automatic test_wrong();
    int m0;
    step_t(4'b0001);
    m0 = d_misses;
    press(4'b1000);
    checks += 3;
    if (d_misses - m0 !== 1) begin errors++; $display("FAIL wrong_pulses got %0d exp 1", d_misses - m0); end
    if (lives !== 2'd2) begin errors++; $display("FAIL wrong_lives got %0d exp 2", lives); end
    if (score_bcd !== 12'h100) begin errors++; $display("FAIL wrong_score got %h exp 100", score_bcd); end
    press(4'b1001);
    checks += 3;
    if (d_misses - m0 !== 2) begin errors++; $display("FAIL mixed_pulses got %0d exp 2", d_misses - m0); end
    if (lives !== 2'd1) begin errors++; $display("FAIL mixed_lives got %0d exp 1", lives); end
    if (score_bcd !== 12'h100) begin errors++; $display("FAIL mixed_score got %h exp 100", score_bcd); end
    step_t(4'b1000);
    checks += 1;
    if (lives !== 2'd1 || d_misses - m0 !== 2) begin errors++; $display("FAIL lane0_marked lives %0d misses %0d exp 1/2", lives, d_misses - m0); end
  endtask
  task automatic test_game_over();
    step_t(4'b0000);
    checks += 3;
    if (!miss_pulse) begin errors++; $display("FAIL close_miss_pulse got 0 exp 1"); end
    if (lives !== 2'd0) begin errors++; $display("FAIL close_miss_lives got %0d exp 0", lives); end
    if (game_state !== 2'b01) begin errors++; $display("FAIL over_delay got %b exp 01", game_state); end
    tick();
    checks += 1;
    if (game_state !== 2'b10) begin errors++; $display("FAIL over_state got %b exp 10", game_state); end
    step_t(4'b1111); tick();
    checks += 1;
    if (game_state !== 2'b10 || score_bcd !== 12'h100 || lives !== 2'd0) begin errors++; $display("FAIL over_frozen got %b/%h/%0d exp 10/100/0", game_state, score_bcd, lives); end
    press(4'b0010);
    checks += 1;
    if (game_state !== 2'b00 || score_bcd !== 12'h100) begin errors++; $display("FAIL over_to_idle got %b/%h exp 00/100", game_state, score_bcd); end
    press(4'b0010);
    checks += 1;
    if (game_state !== 2'b01 || score_bcd !== 12'h000 || lives !== 2'd3) begin errors++; $display("FAIL restart got %b/%h/%0d exp 01/000/3", game_state, score_bcd, lives); end
  endtask
  task automatic test_saturation();
    int h0, m0;
    repeat (249) begin step_t(4'b1111); press(4'b1111); end
    step_t(4'b0011); press(4'b0011);
    checks += 1;
    if (score_bcd !== 12'h998) begin errors++; $display("FAIL pre_sat_score got %h exp 998", score_bcd); end
    step_t(4'b0001);
    m0 = d_misses;
    KEY = 4'b1110; tick(); KEY = 4'hF; tick();
    t = 1; tile_lanes = 4'b0010; tick(); t = 0;
    repeat (2) tick();
    checks += 2;
    if (score_bcd !== 12'h999) begin errors++; $display("FAIL sim_close_score got %h exp 999", score_bcd); end
    if (d_misses !== m0) begin errors++; $display("FAIL sim_close_miss got %0d exp 0", d_misses - m0); end
    h0 = d_hits;
    press(4'b0010);
    checks += 2;
    if (score_bcd !== 12'h999) begin errors++; $display("FAIL sat_score got %h exp 999", score_bcd); end
    if (d_hits - h0 !== 1) begin errors++; $display("FAIL sat_pulse got %0d exp 1", d_hits - h0); end
  endtask
  task automatic test_random();
    reset = 1; tick(); reset = 0;
    m_hits = 0; m_misses = 0; d_hits = 0; d_misses = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) KEY = 4'($urandom);
      t = ($urandom_range(5) == 0);
      tile_lanes = 4'($urandom);
      tick();
      checks += 3;
      if (score_bcd !== m_bcd()) begin errors++; $display("FAIL rand_score cyc %0d got %h exp %h", i, score_bcd, m_bcd()); end
      if (lives !== 2'(m_lives)) begin errors++; $display("FAIL rand_lives cyc %0d got %0d exp %0d", i, lives, m_lives); end
      if (game_state !== 2'(m_state)) begin errors++; $display("FAIL rand_state cyc %0d got %b exp %0d", i, game_state, m_state); end
    end
    checks += 2;
    if (d_hits !== m_hits) begin errors++; $display("FAIL rand_hits got %0d exp %0d", d_hits, m_hits); end
    if (d_misses !== m_misses) begin errors++; $display("FAIL rand_misses got %0d exp %0d", d_misses, m_misses); end
  endtask
  initial begin
    model_reset();
    m_hits = 0; m_misses = 0; d_hits = 0; d_misses = 0;
    test_reset();
    test_single_hit();
    test_carry();
    test_wrong();
    test_game_over();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
